// File: rtl/dram_pkg.sv
// Shared types and defaults for the DRAM command sequencer.
// Build option: DRAM_CMD_CLOSED_PAGE_EN selects auto-precharge accesses (RDA/WRA).
package dram_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_RDA = 3'd5,
    CMD_WRA = 3'd6
  } dram_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECHARGE,
    ST_WAIT_RP,
    ST_ACTIVATE,
    ST_WAIT_RCD,
    ST_ACCESS,
    ST_WAIT_CAS
  } seq_state_e;

  localparam int DEF_NUM_OF_BANKS = 8;
  localparam int DEF_NUM_OF_ROWS  = 128;
  localparam int DEF_NUM_OF_COLS  = 8;
  localparam int DEF_T_RP         = 3;
  localparam int DEF_T_RCD        = 3;
  localparam int DEF_T_CAS        = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Column command for a read/write; auto-precharge flavour in closed-page builds.
  function automatic dram_cmd_e access_cmd(input logic wr);
`ifdef DRAM_CMD_CLOSED_PAGE_EN
    return wr ? CMD_WRA : CMD_RDA;
`else
    return wr ? CMD_WR : CMD_RD;
`endif
  endfunction

endpackage

// File: rtl/dram_bank_table.sv
// Open-row tracker: one open flag and open row per bank, combinational
// hit/conflict lookup, synchronous open/close updates.
module dram_bank_table
  import dram_pkg::*;
#(
  parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
  parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] lk_bank,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  lk_row,
  output logic                            lk_hit,
  output logic                            lk_conflict,
  input  logic                            open_en,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] open_bank,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  open_row,
  input  logic                            close_en,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] close_bank
);

  localparam int BW = $clog2(NUM_OF_BANKS);
  localparam int RW = $clog2(NUM_OF_ROWS);

  logic [NUM_OF_BANKS-1:0]         open_q;
  logic [NUM_OF_BANKS-1:0][RW-1:0] row_q;

  // Per-bank state update; a bank only changes when it is the addressed one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
      row_q  <= '0;
    end else begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        if (open_en && open_bank == BW'(b)) begin
          open_q[b] <= 1'b1;
          row_q[b]  <= open_row;
        end else if (close_en && close_bank == BW'(b)) begin
          open_q[b] <= 1'b0;
        end
      end
    end
  end

  // Lookup against the current table contents.
  always_comb begin
    lk_hit      = open_q[lk_bank] && (row_q[lk_bank] == lk_row);
    lk_conflict = open_q[lk_bank] && (row_q[lk_bank] != lk_row);
  end

endmodule

// File: rtl/dram_cmd_sequencer.sv
// DRAM command sequencer: one request at a time, open-page row tracking,
// emits PRE/ACT/RD/WR with tRP/tRCD/tCAS spacing and a done pulse.
// Build option: DRAM_CMD_CLOSED_PAGE_EN -> RDA/WRA accesses, bank closed after
// every access, plus a tRP recovery wait before returning to idle.
// Command outputs register together with the state, so the command shown in a
// cycle is the command of the state occupied in that cycle.
module dram_cmd_sequencer
  import dram_pkg::*;
#(
  parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
  parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
  parameter int NUM_OF_COLS  = DEF_NUM_OF_COLS,
  parameter int T_RP         = DEF_T_RP,
  parameter int T_RCD        = DEF_T_RCD,
  parameter int T_CAS        = DEF_T_CAS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] bank_id,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  row_id,
  input  logic [$clog2(NUM_OF_COLS)-1:0]  col_id,
  output logic                            cmd_valid,
  output logic [2:0]                      cmd_type,
  output logic [$clog2(NUM_OF_BANKS)-1:0] cmd_bank,
  output logic [$clog2(NUM_OF_ROWS)-1:0]  cmd_row,
  output logic [$clog2(NUM_OF_COLS)-1:0]  cmd_col,
  output logic                            done
);

  localparam int BW  = $clog2(NUM_OF_BANKS);
  localparam int RW  = $clog2(NUM_OF_ROWS);
  localparam int CLW = $clog2(NUM_OF_COLS);
  localparam int CW  = $clog2(max3(T_RP, T_RCD, T_CAS) + 1);

  typedef struct packed {
    logic           write;
    logic [BW-1:0]  bank;
    logic [RW-1:0]  row;
    logic [CLW-1:0] col;
  } req_t;

  seq_state_e    state;
  req_t          req_q;
  logic [CW-1:0] cnt;
  logic          lk_hit;
  logic          lk_conflict;
  logic          open_en;
  logic          close_en;

  // Table updates happen at the end of the PRE/ACT/access command cycle.
  always_comb begin
    open_en = (state == ST_ACTIVATE);
`ifdef DRAM_CMD_CLOSED_PAGE_EN
    close_en = (state == ST_ACCESS);
`else
    close_en = (state == ST_PRECHARGE);
`endif
  end

  dram_bank_table #(
    .NUM_OF_BANKS(NUM_OF_BANKS),
    .NUM_OF_ROWS (NUM_OF_ROWS)
  ) u_bank_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_bank    (bank_id),
    .lk_row     (row_id),
    .lk_hit     (lk_hit),
    .lk_conflict(lk_conflict),
    .open_en    (open_en),
    .open_bank  (req_q.bank),
    .open_row   (req_q.row),
    .close_en   (close_en),
    .close_bank (req_q.bank)
  );

  // Sequencer FSM; each transition also registers the command of the state entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      cnt       <= '0;
      req_ready <= 1'b1;
      cmd_valid <= 1'b0;
      cmd_type  <= CMD_NOP;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      done      <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_type  <= CMD_NOP;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q     <= '{write: req_write, bank: bank_id, row: row_id, col: col_id};
            req_ready <= 1'b0;
            cmd_valid <= 1'b1;
            cmd_bank  <= bank_id;
            if (lk_hit) begin
              state    <= ST_ACCESS;
              cmd_type <= access_cmd(req_write);
              cmd_col  <= col_id;
            end else if (lk_conflict) begin
              state    <= ST_PRECHARGE;
              cmd_type <= CMD_PRE;
            end else begin
              state    <= ST_ACTIVATE;
              cmd_type <= CMD_ACT;
              cmd_row  <= row_id;
            end
          end
        end
`ifdef DRAM_CMD_CLOSED_PAGE_EN
        // Post-access recovery: the auto-precharge needs tRP before the next request.
        ST_WAIT_RP: begin
          if (cnt > CW'(1)) begin
            cnt <= cnt - CW'(1);
          end else begin
            cnt       <= '0;
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            done      <= 1'b1;
          end
        end
`else
        ST_PRECHARGE, ST_WAIT_RP: begin
          if (state == ST_WAIT_RP && cnt > CW'(1)) begin
            cnt <= cnt - CW'(1);
          end else if (state == ST_PRECHARGE && T_RP > 1) begin
            state <= ST_WAIT_RP;
            cnt   <= CW'(T_RP - 1);
          end else begin
            cnt       <= '0;
            state     <= ST_ACTIVATE;
            cmd_valid <= 1'b1;
            cmd_type  <= CMD_ACT;
            cmd_bank  <= req_q.bank;
            cmd_row   <= req_q.row;
          end
        end
`endif
        ST_ACTIVATE, ST_WAIT_RCD: begin
          if (state == ST_WAIT_RCD && cnt > CW'(1)) begin
            cnt <= cnt - CW'(1);
          end else if (state == ST_ACTIVATE && T_RCD > 1) begin
            state <= ST_WAIT_RCD;
            cnt   <= CW'(T_RCD - 1);
          end else begin
            cnt       <= '0;
            state     <= ST_ACCESS;
            cmd_valid <= 1'b1;
            cmd_type  <= access_cmd(req_q.write);
            cmd_bank  <= req_q.bank;
            cmd_col   <= req_q.col;
          end
        end
        ST_ACCESS, ST_WAIT_CAS: begin
          if (state == ST_WAIT_CAS && cnt > CW'(1)) begin
            cnt <= cnt - CW'(1);
          end else if (state == ST_ACCESS && T_CAS > 1) begin
            state <= ST_WAIT_CAS;
            cnt   <= CW'(T_CAS - 1);
          end else begin
`ifdef DRAM_CMD_CLOSED_PAGE_EN
            state <= ST_WAIT_RP;
            cnt   <= CW'(T_RP);
`else
            cnt       <= '0;
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            done      <= 1'b1;
`endif
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Self-checking bench for dram_cmd_sequencer: directed scenarios plus random
// requests, checked cycle by cycle against a schedule computed from the
// open-row table and the tRP/tRCD/tCAS latencies.
module tb_dram_cmd_sequencer;

  localparam int NB   = 8;
  localparam int NR   = 128;
  localparam int NC   = 8;
  localparam int TRP  = 3;
  localparam int TRCD = 3;
  localparam int TCAS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [2:0] bank_id = '0;
  logic [6:0] row_id = '0;
  logic [2:0] col_id = '0;
  logic       req_ready;
  logic       cmd_valid;
  logic [2:0] cmd_type;
  logic [2:0] cmd_bank;
  logic [6:0] cmd_row;
  logic [2:0] cmd_col;
  logic       done;

  always #5 clk = ~clk;

  dram_cmd_sequencer #(
    .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
    .T_RP(TRP), .T_RCD(TRCD), .T_CAS(TCAS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .bank_id(bank_id), .row_id(row_id), .col_id(col_id),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: which row each bank holds open.
  bit m_open[NB];
  int m_row[NB];
  // Expected command schedule of the current request, indexed by cycle after accept.
  int e_type[64];
  int e_row[64];
  int e_col[64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {13'd0, cmd_valid, cmd_type, cmd_bank, cmd_row, cmd_col, done, req_ready};
  endfunction

  function automatic logic [31:0] exp_vec(input int ty, input int b, input int r, input int c,
                                          input bit d, input bit rdy);
    logic v;
    v = (ty != 0);
    return {13'd0, v, 3'(ty), v ? 3'(b) : 3'd0, 7'(r), 3'(c), d, rdy};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = 0;
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle", obs_vec(), exp_vec(0, 0, 0, 0, 1'b0, 1'b1));
    end
  endtask

  // Present one request, then check every cycle up to and including done.
  // hold=1 keeps req_valid high throughout (busy-cycle fields are random junk).
  task automatic do_req(input int b, input int r, input int c, input bit w, input bit hold);
    int  t;
    bit  hit;
    bit  conf;
    for (int i = 0; i < 64; i++) begin
      e_type[i] = 0; e_row[i] = 0; e_col[i] = 0;
    end
    hit  = m_open[b] && (m_row[b] == r);
    conf = m_open[b] && !hit;
    t = 1;
    if (conf) begin
      e_type[t] = 4; t += TRP; m_open[b] = 1'b0;
    end
    if (!hit) begin
      e_type[t] = 1; e_row[t] = r; t += TRCD; m_open[b] = 1'b1; m_row[b] = r;
    end
`ifdef DRAM_CMD_CLOSED_PAGE_EN
    e_type[t] = w ? 6 : 5; e_col[t] = c; t += TCAS + TRP; m_open[b] = 1'b0;
`else
    e_type[t] = w ? 3 : 2; e_col[t] = c; t += TCAS;
`endif
    req_valid = 1'b1;
    req_write = w;
    bank_id   = 3'(b);
    row_id    = 7'(r);
    col_id    = 3'(c);
    @(posedge clk); #1;
    for (int k = 1; k <= t; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      chk($sformatf("b%0d r%0h c%0d w%0d cyc%0d", b, r, c, w, k), obs_vec(),
          exp_vec(e_type[k], b, e_row[k], e_col[k], k == t, k == t));
      req_valid = hold;
      req_write = 1'($urandom_range(1));
      bank_id   = 3'($urandom_range(7));
      row_id    = 7'($urandom_range(127));
      col_id    = 3'($urandom_range(7));
    end
  endtask

  initial begin
    model_reset();
    // Reset state
    #12;
    chk("reset", obs_vec(), exp_vec(0, 0, 0, 0, 1'b0, 1'b1));
    rst_n = 1'b1;
    idle_check(1);

    // Miss, hit, conflict on bank 0
    do_req(0, 'h14, 5, 1'b0, 1'b0);
    do_req(0, 'h14, 2, 1'b1, 1'b0);
    do_req(0, 'h15, 0, 1'b0, 1'b0);
    idle_check(1);

    // Another bank leaves bank 0's row untouched
    do_req(3, 'h7F, 1, 1'b1, 1'b0);
    do_req(0, 'h15, 3, 1'b0, 1'b0);

    // req_valid held high: back-to-back accepts on the done cycle
    do_req(5, 2, 4, 1'b0, 1'b1);
    do_req(5, 2, 6, 1'b1, 1'b1);
    do_req(5, 9, 0, 1'b0, 1'b0);
    idle_check(2);

    // Reset during WAIT_RCD
    req_valid = 1'b1; req_write = 1'b0; bank_id = 3'd2; row_id = 7'h33; col_id = 3'd1;
    @(posedge clk); #1;
    chk("rst_mid_act", obs_vec(), exp_vec(1, 2, 'h33, 0, 1'b0, 1'b0));
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_wait", obs_vec(), exp_vec(0, 0, 0, 0, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async", obs_vec(), exp_vec(0, 0, 0, 0, 1'b0, 1'b1));
    @(posedge clk); #1;
    chk("rst_mid_hold", obs_vec(), exp_vec(0, 0, 0, 0, 1'b0, 1'b1));
    rst_n = 1'b1;
    model_reset();
    idle_check(1);
    do_req(2, 'h33, 1, 1'b0, 1'b0);
    do_req(0, 'h15, 7, 1'b1, 1'b0);

    // Random traffic on a small bank/row window to mix hits, misses and conflicts
    for (int i = 0; i < 24; i++) begin
      bit hold;
      hold = (i == 23) ? 1'b0 : 1'($urandom_range(1));
      do_req(int'($urandom_range(3)), int'($urandom_range(2)), int'($urandom_range(7)),
             1'($urandom_range(1)), hold);
      if (!hold) idle_check(int'($urandom_range(2)));
    end
    idle_check(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
